vip_window_ctrl_5x5: RTL and testbench
======================================

# vip_window_ctrl_5x5

Control and bookkeeping block for the 5x5 window path. It monitors the same raw pixel stream fed to the 5x5 matrix generator and tracks frame, line and pixel position. It emits, aligned to the generator's 4-cycle-delayed window output, a window-valid qualifier, the window-centre coordinates and frame-done/size-error status. Downstream 5x5 filters use `win_valid` to discard border windows built from primed or stale line-buffer data.

## Interface
Parameters:
- `IMG_W`, 640: expected active pixels per line.
- `IMG_H`, 480: expected active lines per frame.
- `CW`, 12: coordinate/counter width; must satisfy 2^CW > max(IMG_W, IMG_H).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `per_frame_vsync`  in  1  raw vsync, active-high; rising edge = frame start.
- `per_frame_href`  in  1  raw line-active.
- `per_frame_clken`  in  1  raw pixel strobe; counted only while href=1.
- `clr_err`  in  1  one-cycle pulse that clears the sticky error flags.
- `win_valid`  out  1  current window has full 5x5 support.
- `win_cx`  out  CW  centre column of the current window (p33).
- `win_cy`  out  CW  centre row of the current window.
- `frame_done`  out  1  one-cycle pulse at the end of the last expected line.
- `err_width`  out  1  sticky: a line had a pixel count different from IMG_W.
- `err_height`  out  1  sticky: a frame had a line count different from IMG_H.
- `state`  out  2  FSM state: 0 IDLE, 1 PRIME, 2 ACTIVE, 3 DONE.

## Operation
- Input edge detection uses a 1-cycle registered copy of vsync and href.
- Counters:
  - `col` counts clken cycles with href=1 and clears on each href rising edge.
  - `row` increments on each href falling edge and clears on vsync rising edge.
  - Both saturate at 2^CW-1.
- Per accepted pixel at input coordinates (x=col, y=row), the stage-0 result is:
  - valid = (x>=4) && (y>=4) && state∈{PRIME, ACTIVE};
  - cx = x-2 and cy = y-2 when valid, otherwise 0.
- FSM:
  - IDLE → PRIME on vsync rising edge. Pixels seen while in IDLE never produce valid.
  - PRIME → ACTIVE on the href falling edge that ends row 3.
  - ACTIVE → DONE on the href falling edge that ends row IMG_H-1; `frame_done` fires from this edge.
  - DONE: any further href is counted for the height check but produces no valid.
  - Any state → PRIME on vsync rising edge (mid-frame vsync restarts the frame).
- Width check: on each href falling edge, col != IMG_W sets `err_width`.
- Height check: on vsync rising edge while state != IDLE, row != IMG_H sets `err_height`.
  - A frame ending early therefore flags on the next vsync.
  - Lines beyond IMG_H also flag.
- Error clear: `clr_err` clears both flags. If a set condition occurs in the same cycle, set wins.

## Timing
- valid/cx/cy/frame_done pass through a 4-stage register pipeline. The result for the input sampled at cycle t appears at t+4, matching generator latency.
- `err_*` and `state` are registered once; no extra alignment.
- Reset values: all outputs 0, state IDLE, counters 0, pipeline cleared.
- Reset mid-frame:
  - Everything returns to reset values and the pipeline is flushed, so no stale `win_valid` emerges after release.
  - The block waits for the next vsync rising edge.
- vsync rise coinciding with an href falling edge: the width check for that line still executes, then counters clear.
- `win_valid` is never asserted when href delayed by 4 is low.

## Test plan
- IMG_W=8, IMG_H=6, 6 lines of 8 continuous pixels:
  - Rows 0–3: `win_valid`=0.
  - Rows 4–5: 4 valid cycles each, cx 2→5 and cy 2 then 3.
  - Each valid asserts exactly 4 cycles after its input pixel.
  - `frame_done` pulses once, 4 cycles after row 5's href falls.
  - `state` reads 3.
- Line 2 has 7 pixels → `err_width`=1 after that href falls. Remains 1 through the next frame until a `clr_err` pulse clears it.
- Only 5 lines, then vsync → `err_height`=1 one cycle after vsync rise. `frame_done` never pulses for that frame.
- `clr_err` asserted in the same cycle as a short-line href fall → `err_width` stays 1.
- `rst_n` low for 2 cycles during row 4 with valid windows in flight → all outputs 0 immediately. No valid after release until a new vsync, then normal valid from row 4 of that frame.
- Pixels presented before any vsync after reset, then a vsync mid-line → no valid before the vsync, `state` PRIME after it, and `err_height` not set on that first vsync (previous state IDLE).

Source files
------------

// File: rtl/vip_window_ctrl_5x5.sv
// Frame/line/pixel bookkeeping for the 5x5 window path: tracks raw-stream position and emits
// window-valid, centre coordinates and frame status aligned to the generator's 4-cycle latency.
module vip_window_ctrl_5x5 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic          clr_err,
    output logic          win_valid,
    output logic [CW-1:0] win_cx,
    output logic [CW-1:0] win_cy,
    output logic          frame_done,
    output logic          err_width,
    output logic          err_height,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          fd;
        logic [CW-1:0] cx;
        logic [CW-1:0] cy;
    } win_t;

    localparam int            LAT     = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] W_EXP   = CW'(IMG_W);
    localparam logic [CW-1:0] H_EXP   = CW'(IMG_H);
    localparam logic [CW-1:0] H_LAST  = CW'(IMG_H - 1);
    localparam logic [CW-1:0] ROW_3   = CW'(3);
    localparam logic [CW-1:0] EDGE    = CW'(4);
    localparam logic [CW-1:0] HALF    = CW'(2);

    state_t        st;
    logic          vsync_d;
    logic          href_d;
    logic          vs_rise;
    logic          h_rise;
    logic          h_fall;
    logic          pix;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    win_t          s0;
    win_t          pipe [LAT];

    // x/y are the coordinates of the pixel accepted this cycle, with the edge-triggered
    // clears applied early so the first pixel of a line/frame sees 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        s0      = '0;
        vs_rise = per_frame_vsync & ~vsync_d;
        h_rise  = per_frame_href & ~href_d;
        h_fall  = ~per_frame_href & href_d;
        pix     = per_frame_href & per_frame_clken;
        x       = h_rise ? '0 : col;
        y       = vs_rise ? '0 : row;
        s0.valid = pix && (x >= EDGE) && (y >= EDGE) && (st == S_PRIME || st == S_ACTIVE);
        if (s0.valid) begin
            s0.cx = x - HALF;
            s0.cy = y - HALF;
        end
        s0.fd = h_fall && (st == S_ACTIVE) && (row == H_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            vsync_d <= per_frame_vsync;
            href_d  <= per_frame_href;
            if (pix)
                col <= (x == CNT_MAX) ? x : x + 1'b1;
            else if (h_rise)
                col <= '0;
            if (vs_rise)
                row <= '0;
            else if (h_fall && row != CNT_MAX)
                row <= row + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_IDLE;
        end else if (vs_rise) begin
            st <= S_PRIME;
        end else if (h_fall) begin
            case (st)
                S_PRIME:  if (row == ROW_3)  st <= S_ACTIVE;
                S_ACTIVE: if (row == H_LAST) st <= S_DONE;
                default:  st <= st;
            endcase
        end
    end

    // Set takes priority over clear so a same-cycle error is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_width  <= 1'b0;
            err_height <= 1'b0;
        end else begin
            if (h_fall && col != W_EXP)
                err_width <= 1'b1;
            else if (clr_err)
                err_width <= 1'b0;
            if (vs_rise && st != S_IDLE && row != H_EXP)
                err_height <= 1'b1;
            else if (clr_err)
                err_height <= 1'b0;
        end
    end

    // NOTE: the alignment pipeline is reset, unlike a data RAM, so a reset flushes windows in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= s0;
            for (int i = 1; i < LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign win_valid  = pipe[LAT-1].valid;
    assign win_cx     = pipe[LAT-1].cx;
    assign win_cy     = pipe[LAT-1].cy;
    assign frame_done = pipe[LAT-1].fd;
    assign state      = st;

endmodule

// File: tb/tb_vip_window_ctrl_5x5.sv
// Self-checking bench for vip_window_ctrl_5x5 on an 8x6 image; aligned outputs are
// checked through a scoreboard queue, status outputs every cycle.
module tb_vip_window_ctrl_5x5;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int CW    = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vs, hr, ck, clr;
    logic          win_valid, frame_done, err_width, err_height;
    logic [CW-1:0] win_cx, win_cy;
    logic [1:0]    state;

    vip_window_ctrl_5x5 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (vs),
        .per_frame_href  (hr),
        .per_frame_clken (ck),
        .clr_err         (clr),
        .win_valid       (win_valid),
        .win_cx          (win_cx),
        .win_cy          (win_cy),
        .frame_done      (frame_done),
        .err_width       (err_width),
        .err_height      (err_height),
        .state           (state)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q [$];
    int          exp_st, exp_ew, exp_eh, line_cnt;
    logic        vs_lvl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input bit v, input bit fd, input int cx, input int cy);
        return {6'd0, v, fd, cx[CW-1:0], cy[CW-1:0]};
    endfunction

    // One clock: drive, sample 1 ns after the edge, compare the result pushed three steps ago.
    task automatic step(input bit h, input bit c, input bit cl,
                        input bit v, input int cx, input int cy, input bit fd);
        vs = vs_lvl; hr = h; ck = c; clr = cl;
        @(posedge clk); #1;
        exp_q.push_back(pack(v, fd, cx, cy));
        check("win", pack(win_valid, frame_done, int'(win_cx), int'(win_cy)), exp_q.pop_front());
        check("err_width", 32'(err_width), exp_ew);
        check("err_height", 32'(err_height), exp_eh);
        check("state", 32'(state), exp_st);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_vsync_rise();
        if (exp_st != 0 && line_cnt != IMG_H) exp_eh = 1;
        exp_st   = 1;
        line_cnt = 0;
        vs_lvl   = 1'b1;
    endtask

    task automatic vsync_pulse();
        model_vsync_rise();
        idle(2);
        vs_lvl = 1'b0;
        idle(2);
    endtask

    task automatic clear_errs();
        exp_ew = 0;
        exp_eh = 0;
        step(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic pixel(input int x);
        bit v;
        v = (exp_st == 1 || exp_st == 2) && x >= 4 && line_cnt >= 4;
        step(1, 1, 0, v, v ? x - 2 : 0, v ? line_cnt - 2 : 0, 0);
    endtask

    // vs_at >= 0 raises vsync on that pixel of the line and holds it to the line end.
    task automatic send_line(input int npix, input bit gap, input bit clr_end, input int vs_at);
        bit fd;
        for (int x = 0; x < npix; x++) begin
            if (x == vs_at) model_vsync_rise();
            pixel(x);
            if (gap) step(1, 0, 0, 0, 0, 0, 0);
        end
        fd = (exp_st == 2 && line_cnt == IMG_H - 1);
        if (clr_end) begin
            exp_eh = 0;
            exp_ew = (npix != IMG_W);
        end else if (npix != IMG_W) begin
            exp_ew = 1;
        end
        if (exp_st == 1 && line_cnt == 3)              exp_st = 2;
        else if (exp_st == 2 && line_cnt == IMG_H - 1) exp_st = 3;
        line_cnt++;
        step(0, 0, clr_end, 0, 0, 0, fd);
        vs_lvl = 1'b0;
        idle(2);
    endtask

    task automatic send_frame(input int nlines, input bit gap, input int short_line);
        vsync_pulse();
        for (int l = 0; l < nlines; l++)
            send_line((l == short_line) ? IMG_W - 1 : IMG_W, gap, 0, -1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
        exp_st = 0; exp_ew = 0; exp_eh = 0; line_cnt = 0; vs_lvl = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(win_valid), 0);
        check({tag, "_cx"}, 32'(win_cx), 0);
        check({tag, "_cy"}, 32'(win_cy), 0);
        check({tag, "_fd"}, 32'(frame_done), 0);
        check({tag, "_ew"}, 32'(err_width), 0);
        check({tag, "_eh"}, 32'(err_height), 0);
        check({tag, "_state"}, 32'(state), 0);
    endtask

    // Called 1 ns after an edge: asserts reset between edges and checks outputs clear at once.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        vs = 0; hr = 0; ck = 0; clr = 0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        vs = 0; hr = 0; ck = 0; clr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Pixels before any vsync, then a vsync rising mid-line.
        for (int l = 0; l < 5; l++) send_line(IMG_W, 0, 0, -1);
        send_line(IMG_W, 0, 0, 3);
        idle(2);
        apply_reset();

        // Clean frame, then width error that persists into the next frame.
        send_frame(IMG_H, 0, -1);
        idle(3);
        send_frame(IMG_H, 1, 2);
        send_frame(IMG_H, 0, -1);
        clear_errs();

        // Clear coinciding with a short-line href fall: set wins.
        vsync_pulse();
        send_line(IMG_W, 0, 0, -1);
        send_line(IMG_W - 1, 0, 1, -1);
        for (int l = 2; l < IMG_H; l++) send_line(IMG_W, 0, 0, -1);
        clear_errs();

        // Short frame, then a frame with an extra line: both flag on the following vsync.
        send_frame(5, 0, -1);
        vsync_pulse();
        clear_errs();
        for (int l = 0; l < IMG_H + 1; l++) send_line(IMG_W, 0, 0, -1);
        vsync_pulse();
        clear_errs();

        // Reset during row 4 with valid windows in the pipeline.
        for (int l = 0; l < 4; l++) send_line(IMG_W, 0, 0, -1);
        for (int x = 0; x < IMG_W; x++) pixel(x);
        apply_reset();
        for (int l = 0; l < 5; l++) send_line(IMG_W, 0, 0, -1);
        send_frame(IMG_H, 0, -1);
        idle(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
